// File: rtl/p1_fetch.sv
// Fetch stage: one outstanding instruction-memory read feeding a 2-entry buffer
// that presents pc/instruction to the p1p2 pipeline register.
package p1_fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } p1p2_t;
endpackage

module p1_fetch
  import p1_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output p1p2_t       o_p1p2
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] req_pc_reg;
  logic [1:0]  count_reg;
  logic        head_reg;
  logic        tail_reg;

  logic [31:0] pc_ent    [FIFO_DEPTH];
  logic [31:0] instr_ent [FIFO_DEPTH];

  logic        req_fire;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;
  logic [31:0] head_pc;
  logic        unused_redirect_bits;

  assign o_imem_req_valid = (state_reg == S_REQ) && (count_reg < 2'd2);
  assign o_imem_req_addr  = (state_reg == S_REQ) ? fetch_pc_reg : 32'h0;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;
  assign redirect_target  = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^i_redirect_pc[1:0];

  // A redirect wins over everything: it suppresses both the push and the pop.
  assign push = (state_reg == S_WAIT) && i_imem_rsp_valid && !i_redirect_valid;
  assign pop  = o_valid && !i_stall && !i_redirect_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= S_REQ;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= 32'h0;
      count_reg    <= 2'd0;
      head_reg     <= 1'b0;
      tail_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (i_redirect_valid) begin
            state_reg <= req_fire ? S_DROP : S_REQ;
          end else if (req_fire) begin
            state_reg  <= S_WAIT;
            req_pc_reg <= fetch_pc_reg;
          end
        end
        S_WAIT: begin
          if (i_redirect_valid) begin
            state_reg <= i_imem_rsp_valid ? S_REQ : S_DROP;
          end else if (i_imem_rsp_valid) begin
            state_reg <= S_REQ;
          end
        end
        S_DROP: begin
          if (i_imem_rsp_valid) begin
            state_reg <= S_REQ;
          end
        end
        default: state_reg <= S_REQ;
      endcase

      if (i_redirect_valid) begin
        fetch_pc_reg <= redirect_target;
      end else if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end

      if (i_redirect_valid) begin
        count_reg <= 2'd0;
        head_reg  <= 1'b0;
        tail_reg  <= 1'b0;
      end else begin
        count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        if (push) tail_reg <= ~tail_reg;
        if (pop)  head_reg <= ~head_reg;
      end
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        pc_reg    <= 32'h0;
        instr_reg <= 32'h0;
      end else if (push && (tail_reg == 1'(gi))) begin
        pc_reg    <= req_pc_reg;
        instr_reg <= i_imem_rsp_data;
      end
    end

    assign pc_ent[gi]    = pc_reg;
    assign instr_ent[gi] = instr_reg;
  end

  assign o_valid          = (count_reg != 2'd0);
  assign head_pc          = pc_ent[head_reg];
  assign o_instr          = o_valid ? instr_ent[head_reg] : 32'h0;
  assign o_p1p2.pc        = o_valid ? head_pc : 32'h0;
  assign o_p1p2.pc_plus_4 = o_valid ? (head_pc + 32'd4) : 32'h0;

  // A response can only follow an accepted request, so none may arrive in S_REQ.
  rsp_without_request : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
      !((state_reg == S_REQ) && i_imem_rsp_valid)
  ) else $error("imem response received with no request outstanding");

endmodule

// File: tb/tb_p1_fetch.sv
// Bench for p1_fetch: directed scenarios then random traffic, all compared against
// a transaction-level model (entry queue, fetch pointer, outstanding-request status).
module tb_p1_fetch;
  import p1_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready = 1'b0;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data = 32'h0;
  logic        i_stall = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_valid;
  logic [31:0] o_instr;
  p1p2_t       o_p1p2;

  p1_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_stall          (i_stall),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_valid          (o_valid),
    .o_instr          (o_instr),
    .o_p1p2           (o_p1p2)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Model: delivered-but-unconsumed instructions, next fetch address,
  // and whether the one in-flight request is live (1) or stale (2).
  ent_t        q[$];
  logic [31:0] popped[$];
  logic [31:0] m_fpc;
  logic [31:0] m_live_pc;
  int          outst;

  // Memory environment: one pending read with a latency countdown.
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg;
  bit          rand_lat;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_fpc    = RESET_PC;
    outst    = 0;
    mem_pend = 1'b0;
    mem_cnt  = 0;
  endfunction

  task automatic compare_all();
    bit exp_rv;
    exp_rv = (outst == 0) && (q.size() < 2);
    check("req_valid", 32'(o_imem_req_valid), 32'(exp_rv));
    check("req_addr", o_imem_req_addr, (outst == 0) ? m_fpc : 32'h0);
    check("o_valid", 32'(o_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("instr", o_instr, q[0].instr);
      check("head_pc", o_p1p2.pc, q[0].pc);
      check("pc_plus_4", o_p1p2.pc_plus_4, q[0].pc + 32'd4);
    end
  endtask

  task automatic step(input bit rdy, input bit stl, input bit rd, input logic [31:0] rpc);
    bit          hs;
    bit          rsp;
    logic [31:0] data;
    hs   = (outst == 0) && (q.size() < 2) && rdy;
    rsp  = mem_pend && (mem_cnt == 0);
    data = rsp ? imem_word(mem_addr) : $urandom();
    i_imem_req_ready = rdy;
    i_stall          = stl;
    i_redirect_valid = rd;
    i_redirect_pc    = rpc;
    i_imem_rsp_valid = rsp;
    i_imem_rsp_data  = data;
    @(posedge i_clk);
    if (rsp) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (hs) begin
      mem_pend = 1'b1;
      mem_addr = m_fpc;
      mem_cnt  = rand_lat ? int'($urandom_range(0, 2)) : lat_cfg - 1;
    end
    if (rd) begin
      q.delete();
      m_fpc = {rpc[31:2], 2'b00};
      if (outst == 0) outst = hs ? 2 : 0;
      else outst = rsp ? 0 : 2;
    end else begin
      if (q.size() != 0 && !stl) begin
        popped.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (hs) begin
        outst     = 1;
        m_live_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end else if (rsp) begin
        if (outst == 1) q.push_back('{m_live_pc, data});
        outst = 0;
      end
    end
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    lat_cfg  = 1;
    rand_lat = 1'b0;

    // Reset values, then first request right after release.
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'h0);
    check("rst_o_instr", o_instr, 32'h0);
    check("rst_pc", o_p1p2.pc, 32'h0);
    check("rst_pc_plus_4", o_p1p2.pc_plus_4, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("post_rst_req_valid", 32'(o_imem_req_valid), 32'h1);
    check("post_rst_req_addr", o_imem_req_addr, RESET_PC);

    // Streaming with single-cycle memory.
    popped.delete();
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("stream_count", 32'(popped.size() >= 3), 32'h1);
    if (popped.size() >= 3) begin
      check("stream_pc0", popped[0], 32'h0);
      check("stream_pc1", popped[1], 32'h4);
      check("stream_pc2", popped[2], 32'h8);
    end

    // Backpressure: buffer fills, requests stop, head holds.
    step(1'b1, 1'b1, 1'b1, 32'h0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("bp_req_valid", 32'(o_imem_req_valid), 32'h0);
    check("bp_head_pc", o_p1p2.pc, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("bp_release_valid", 32'(o_valid), 32'h1);
    check("bp_release_pc", o_p1p2.pc, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect while a request is outstanding and no response this cycle.
    lat_cfg = 3;
    for (int k = 0; k < 40 && !(outst == 1 && mem_cnt > 0); k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("wait_setup", 32'(outst == 1 && mem_cnt > 0), 32'h1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0102);
    check("drop_req_valid", 32'(o_imem_req_valid), 32'h0);
    check("drop_o_valid", 32'(o_valid), 32'h0);
    for (int k = 0; k < 20 && !o_imem_req_valid; k++) begin
      check("drop_hold_o_valid", 32'(o_valid), 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
    end
    check("redir_req_addr", o_imem_req_addr, 32'h0000_0100);
    for (int k = 0; k < 20 && !o_valid; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_head_pc", o_p1p2.pc, 32'h0000_0100);

    // Redirect coincident with a response, stalled, one entry buffered.
    lat_cfg = 1;
    step(1'b1, 1'b1, 1'b1, 32'h300);
    for (int k = 0; k < 40 && !(q.size() == 1 && outst == 1 && mem_pend && mem_cnt == 0); k++)
      step(1'b1, 1'b1, 1'b0, 32'h0);
    check("coinc_setup", 32'(q.size() == 1 && outst == 1 && mem_pend && mem_cnt == 0), 32'h1);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    check("coinc_o_valid", 32'(o_valid), 32'h0);
    check("coinc_req_valid", 32'(o_imem_req_valid), 32'h1);
    check("coinc_req_addr", o_imem_req_addr, 32'h200);

    // Address wrap at the top of the space; low redirect bits are masked.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    for (int k = 0; k < 20 && !o_valid; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_head_pc", o_p1p2.pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus_4", o_p1p2.pc_plus_4, 32'h0);
    for (int k = 0; k < 20 && !o_imem_req_valid; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_next_addr", o_imem_req_addr, 32'h0);

    // Asynchronous reset with data buffered and a request in flight.
    lat_cfg = 3;
    for (int k = 0; k < 40 && !(q.size() >= 1 && outst != 0); k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rst2_setup", 32'(q.size() >= 1 && outst != 0), 32'h1);
    i_rst_n          = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_req_ready = 1'b0;
    i_redirect_valid = 1'b0;
    #1;
    check("rst2_o_valid", 32'(o_valid), 32'h0);
    check("rst2_pc", o_p1p2.pc, 32'h0);
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("rst2_req_valid", 32'(o_imem_req_valid), 32'h1);
    check("rst2_req_addr", o_imem_req_addr, RESET_PC);

    // Random traffic.
    rand_lat = 1'b1;
    repeat (1500) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
